// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32 subset datapath (R/I-type ALU, lw, sw, beq).
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and traps on bad opcodes or memory timeout.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    input  logic             Stall,
    output logic             InstrRead,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCBranch,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Illegal,
    output logic             Timeout,
    output logic [CNT_W-1:0] RetireCount,
    output logic [2:0]       State
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t             state_reg, state_next;
    logic [6:0]         op_reg, op_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic [CNT_W-1:0]   retire_reg, retire_next;
    logic               illegal_reg, illegal_next;
    logic               timeout_reg, timeout_next;

    logic       instr_read, ir_write, pc_write, pc_branch, alu_src;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, mem_to_reg, reg_write;
    logic       retire;
    logic       go;
    logic       is_lw, is_sw, is_beq, is_itype, opcode_legal;

    assign go           = !Stall;
    assign is_lw        = (op_reg == OP_LW);
    assign is_sw        = (op_reg == OP_SW);
    assign is_beq       = (op_reg == OP_BEQ);
    assign is_itype     = (op_reg == OP_I);
    assign opcode_legal = (Opcode == OP_R) || (Opcode == OP_I) || (Opcode == OP_LW) ||
                          (Opcode == OP_SW) || (Opcode == OP_BEQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            op_reg      <= '0;
            wait_reg    <= '0;
            retire_reg  <= '0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            wait_reg    <= wait_next;
            retire_reg  <= retire_next;
            illegal_reg <= illegal_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        wait_next    = wait_reg;
        illegal_next = illegal_reg;
        timeout_next = timeout_reg;
        instr_read   = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_branch    = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        retire       = 1'b0;

        case (state_reg)
            FETCH: begin
                instr_read = go;
                if (go) begin
                    if (MemReady) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_next   = TRAP;
                        timeout_next = 1'b1;
                    end else begin
                        wait_next = wait_reg + 1'b1;
                    end
                end
            end
            DECODE: begin
                if (go) begin
                    op_next = Opcode;
                    if (opcode_legal) begin
                        state_next = EXEC;
                    end else begin
                        state_next   = TRAP;
                        illegal_next = 1'b1;
                    end
                end
            end
            EXEC: begin
                alu_src = is_lw || is_sw || is_itype;
                alu_op  = is_beq ? 2'b01 : ((is_lw || is_sw) ? 2'b00 : 2'b10);
                if (go) begin
                    if (is_beq) begin
                        pc_branch  = Zero;
                        retire     = 1'b1;
                        state_next = FETCH;
                        wait_next  = '0;
                    end else if (is_lw || is_sw) begin
                        state_next = MEM;
                        wait_next  = '0;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            MEM: begin
                alu_src   = 1'b1;
                mem_read  = go && is_lw;
                mem_write = go && is_sw;
                if (go) begin
                    if (MemReady) begin
                        if (is_lw) begin
                            state_next = WB;
                        end else begin
                            retire     = 1'b1;
                            state_next = FETCH;
                            wait_next  = '0;
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        state_next   = TRAP;
                        timeout_next = 1'b1;
                    end else begin
                        wait_next = wait_reg + 1'b1;
                    end
                end
            end
            WB: begin
                alu_src    = is_lw || is_itype;
                alu_op     = is_lw ? 2'b00 : 2'b10;
                mem_to_reg = is_lw;
                reg_write  = go;
                if (go) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                    wait_next  = '0;
                end
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                // Unused encodings park in TRAP without raising a flag.
                state_next = TRAP;
            end
        endcase

        retire_next = retire ? retire_reg + 1'b1 : retire_reg;
    end

    // Reset masks every output except the raw state, in the same cycle.
    assign InstrRead   = instr_read & ~reset;
    assign IRWrite     = ir_write & ~reset;
    assign PCWrite     = pc_write & ~reset;
    assign PCBranch    = pc_branch & ~reset;
    assign ALUSrc      = alu_src & ~reset;
    assign ALUOp       = reset ? 2'b00 : alu_op;
    assign MemRead     = mem_read & ~reset;
    assign MemWrite    = mem_write & ~reset;
    assign MemtoReg    = mem_to_reg & ~reset;
    assign RegWrite    = reg_write & ~reset;
    assign Illegal     = illegal_reg & ~reset;
    assign Timeout     = timeout_reg & ~reset;
    assign RetireCount = reset ? '0 : retire_reg;
    assign State       = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: each stimulus cycle queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Bit masks in the packed order {InstrRead,IRWrite,PCWrite,PCBranch,ALUSrc,ALUOp,MemRead,MemWrite,MemtoReg,RegWrite,Illegal,Timeout}
    localparam logic [12:0] IRD  = 13'h1000;
    localparam logic [12:0] IRW  = 13'h0800;
    localparam logic [12:0] PCW  = 13'h0400;
    localparam logic [12:0] PCB  = 13'h0200;
    localparam logic [12:0] ASRC = 13'h0100;
    localparam logic [12:0] OPR  = 13'h0080;
    localparam logic [12:0] OPB  = 13'h0040;
    localparam logic [12:0] MRD  = 13'h0020;
    localparam logic [12:0] MWR  = 13'h0010;
    localparam logic [12:0] M2R  = 13'h0008;
    localparam logic [12:0] RWR  = 13'h0004;
    localparam logic [12:0] ILL  = 13'h0002;
    localparam logic [12:0] TMO  = 13'h0001;
    localparam logic [12:0] ACK  = IRD | IRW | PCW;

    logic        clk;
    logic        reset;
    logic [6:0]  Opcode;
    logic        Zero, MemReady, Stall;
    logic        InstrRead, IRWrite, PCWrite, PCBranch, ALUSrc;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite, MemtoReg, RegWrite, Illegal, Timeout;
    logic [31:0] RetireCount;
    logic [2:0]  State;

    typedef struct {
        logic [2:0]  st;
        logic [12:0] sb;
        logic [31:0] rc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [12:0] obs;

    multicycle_control_fsm #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .Stall(Stall), .InstrRead(InstrRead), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCBranch(PCBranch), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Illegal(Illegal),
        .Timeout(Timeout), .RetireCount(RetireCount), .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            obs = {InstrRead, IRWrite, PCWrite, PCBranch, ALUSrc, ALUOp,
                   MemRead, MemWrite, MemtoReg, RegWrite, Illegal, Timeout};
            vectors++;
            if (State !== cur.st || obs !== cur.sb || RetireCount !== cur.rc) begin
                miscompares++;
                $display("FAIL %s: got state=%0d strobes=%b retire=%0d, expected state=%0d strobes=%b retire=%0d",
                         cur.name, State, obs, RetireCount, cur.st, cur.sb, cur.rc);
            end else begin
                $display("vec %0d %s state=%0d strobes=%b retire=%0d ok",
                         vectors, cur.name, State, obs, RetireCount);
            end
        end
    end

    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic mr,
                        input logic st, input logic [2:0] es, input logic [12:0] esb,
                        input logic [31:0] erc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = r;
        Opcode   = op;
        Zero     = z;
        MemReady = mr;
        Stall    = st;
        e.st = es; e.sb = esb; e.rc = erc; e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; Opcode = OP_R; Zero = 1'b0; MemReady = 1'b0; Stall = 1'b0;

        step(1, OP_R, 0, 0, 0, 3'd0, 13'h0, 0, "reset_a");
        step(1, OP_R, 0, 1, 0, 3'd0, 13'h0, 0, "reset_b");

        // R-type, fetch acked on the third request cycle
        step(0, OP_R, 0, 0, 0, 3'd0, IRD, 0, "r_fetch0");
        step(0, OP_R, 0, 0, 0, 3'd0, IRD, 0, "r_fetch1");
        step(0, OP_R, 0, 1, 0, 3'd0, ACK, 0, "r_fetch_ack");
        step(0, OP_R, 0, 0, 0, 3'd1, 13'h0, 0, "r_decode");
        step(0, OP_R, 0, 0, 0, 3'd2, OPR, 0, "r_exec");
        step(0, OP_R, 0, 0, 0, 3'd4, OPR | RWR, 0, "r_wb");

        // lw with three wait cycles in MEM
        step(0, OP_LW, 0, 1, 0, 3'd0, ACK, 1, "lw_fetch");
        step(0, OP_LW, 0, 0, 0, 3'd1, 13'h0, 1, "lw_decode");
        step(0, OP_LW, 0, 0, 0, 3'd2, ASRC, 1, "lw_exec");
        for (int i = 0; i < 3; i++)
            step(0, OP_LW, 0, 0, 0, 3'd3, MRD | ASRC, 1, "lw_mem_wait");
        step(0, OP_LW, 0, 1, 0, 3'd3, MRD | ASRC, 1, "lw_mem_ack");
        step(0, OP_LW, 0, 0, 0, 3'd4, ASRC | M2R | RWR, 1, "lw_wb");

        // beq taken then not taken
        step(0, OP_BEQ, 0, 1, 0, 3'd0, ACK, 2, "beq_fetch");
        step(0, OP_BEQ, 0, 0, 0, 3'd1, 13'h0, 2, "beq_decode");
        step(0, OP_BEQ, 1, 0, 0, 3'd2, OPB | PCB, 2, "beq_taken");
        step(0, OP_BEQ, 0, 1, 0, 3'd0, ACK, 3, "beq2_fetch");
        step(0, OP_BEQ, 0, 0, 0, 3'd1, 13'h0, 3, "beq2_decode");
        step(0, OP_BEQ, 0, 0, 0, 3'd2, OPB, 3, "beq_not_taken");

        // sw with stall over an ack that must be ignored
        step(0, OP_SW, 0, 1, 0, 3'd0, ACK, 4, "sw_fetch");
        step(0, OP_SW, 0, 0, 0, 3'd1, 13'h0, 4, "sw_decode");
        step(0, OP_SW, 0, 0, 0, 3'd2, ASRC, 4, "sw_exec");
        step(0, OP_SW, 0, 1, 1, 3'd3, ASRC, 4, "sw_stall_a");
        step(0, OP_SW, 0, 1, 1, 3'd3, ASRC, 4, "sw_stall_b");
        step(0, OP_SW, 0, 0, 0, 3'd3, MWR | ASRC, 4, "sw_mem_wait");
        step(0, OP_SW, 0, 1, 0, 3'd3, MWR | ASRC, 4, "sw_mem_ack");

        // Fetch acked in the last permitted wait cycle, then illegal opcode trap
        for (int i = 0; i < 15; i++)
            step(0, OP_BAD, 0, 0, 0, 3'd0, IRD, 5, "late_fetch_wait");
        step(0, OP_BAD, 0, 1, 0, 3'd0, ACK, 5, "late_fetch_ack");
        step(0, OP_BAD, 0, 0, 0, 3'd1, 13'h0, 5, "bad_decode");
        for (int i = 0; i < 20; i++)
            step(0, OP_BAD, logic'(i[0]), logic'(i[1]), logic'(i[2]), 3'd5, ILL, 5, "illegal_trap");
        step(1, OP_BAD, 0, 0, 0, 3'd5, 13'h0, 0, "trap_reset");

        // I-type after reset
        step(0, OP_I, 0, 1, 0, 3'd0, ACK, 0, "i_fetch");
        step(0, OP_I, 0, 0, 0, 3'd1, 13'h0, 0, "i_decode");
        step(0, OP_I, 0, 0, 0, 3'd2, ASRC | OPR, 0, "i_exec");
        step(0, OP_I, 0, 0, 0, 3'd4, ASRC | OPR | RWR, 0, "i_wb");

        // Fetch timeout: 16 unanswered request cycles
        for (int i = 0; i < 16; i++)
            step(0, OP_R, 0, 0, 0, 3'd0, IRD, 1, "timeout_wait");
        step(0, OP_R, 0, 1, 0, 3'd5, TMO, 1, "timeout_trap_a");
        step(0, OP_R, 0, 1, 1, 3'd5, TMO, 1, "timeout_trap_b");
        step(1, OP_R, 0, 0, 0, 3'd5, 13'h0, 0, "timeout_reset");

        // Reset during WB aborts without a write or retire
        step(0, OP_R, 0, 1, 0, 3'd0, ACK, 0, "abort_fetch");
        step(0, OP_R, 0, 0, 0, 3'd1, 13'h0, 0, "abort_decode");
        step(0, OP_R, 0, 0, 0, 3'd2, OPR, 0, "abort_exec");
        step(1, OP_R, 0, 0, 0, 3'd4, 13'h0, 0, "abort_reset_in_wb");
        step(0, OP_R, 0, 0, 0, 3'd0, IRD, 0, "abort_refetch");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
